// File: rtl/e203_rfctx_pkg.sv
// Shared types and slot-mapping helpers for the context save/restore register file.
package e203_rfctx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SAVE    = 2'd1,
        ST_RESTORE = 2'd2
    } rfctx_state_e;

    localparam logic [31:0] DEF_SAVE_MASK = 32'hF003_FCE2;
    localparam int unsigned DEF_LANES     = 4;

    // True when register idx is selected by mask.
    function automatic logic mask_has(input logic [31:0] mask, input int unsigned idx);
        logic [31:0] sh;
        sh = mask >> idx;
        return sh[0];
    endfunction

    // Number of saved registers; x0 is never saved.
    function automatic int unsigned popcount(input logic [31:0] mask);
        int unsigned n;
        n = 0;
        for (int unsigned b = 1; b < 32; b++) begin
            if (mask_has(mask, b)) n++;
        end
        return n;
    endfunction

    // Register index carried by slot s (s-th masked register, ascending).
    function automatic int unsigned slot_idx(input logic [31:0] mask, input int unsigned s);
        int unsigned n;
        int unsigned idx;
        n   = 0;
        idx = 0;
        for (int unsigned b = 1; b < 32; b++) begin
            if (mask_has(mask, b)) begin
                if (n == s) idx = b;
                n++;
            end
        end
        return idx;
    endfunction

    // Beats needed for nslot registers; at least one so the engine always terminates.
    function automatic int unsigned nbeat(input int unsigned nslot, input int unsigned lanes);
        return (nslot == 0) ? 1 : (nslot + lanes - 1) / lanes;
    endfunction

    localparam int unsigned DEF_NSLOT = popcount(DEF_SAVE_MASK);
    localparam int unsigned DEF_NBEAT = nbeat(DEF_NSLOT, DEF_LANES);

endpackage

// File: rtl/e203_rfctx_seq.sv
// Save/restore sequencer: FSM, beat counter, return-address capture and done pulse.
module e203_rfctx_seq
    import e203_rfctx_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NBEAT  = 4,
    parameter int unsigned BCNT_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              save_req,
    input  logic              restore_req,
    input  logic [XLEN-1:0]   ra_dat,
    input  logic              sv_ready,
    input  logic              rs_valid,
    output logic              busy,
    output logic              done,
    output logic              sv_valid,
    output logic              sv_last,
    output logic              rs_ready,
    output logic [BCNT_W-1:0] bcnt,
    output logic [XLEN-1:0]   ra_q,
    output logic              save_fire,
    output logic              restore_fire
);

    rfctx_state_e state;
    rfctx_state_e state_nxt;
    logic         last_beat;

    assign last_beat = (bcnt == BCNT_W'(NBEAT - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next state: save wins over restore; requests are only sampled in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (save_req)         state_nxt = ST_SAVE;
                else if (restore_req) state_nxt = ST_RESTORE;
            end
            ST_SAVE: begin
                if (save_fire && last_beat) state_nxt = ST_IDLE;
            end
            ST_RESTORE: begin
                if (restore_fire && last_beat) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Handshake outputs and fire strobes, decoded from state.
    always_comb begin
        busy         = (state != ST_IDLE);
        sv_valid     = (state == ST_SAVE);
        rs_ready     = (state == ST_RESTORE);
        sv_last      = sv_valid && last_beat;
        save_fire    = sv_valid && sv_ready;
        restore_fire = rs_ready && rs_valid;
    end

    // Beat counter: advances per accepted beat, wraps to 0 after the last one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt <= '0;
        end else if (save_fire || restore_fire) begin
            bcnt <= last_beat ? '0 : bcnt + 1'b1;
        end
    end

    // Capture the x1 reload value together with an accepted save request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ra_q <= '0;
        end else if (state == ST_IDLE && save_req) begin
            ra_q <= ra_dat;
        end
    end

    // One-cycle done pulse in the cycle after the final beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) done <= 1'b0;
        else     done <= (save_fire || restore_fire) && last_beat;
    end

endmodule

// File: rtl/e203_exu_regfile_ctx.sv
// EXU register file with a masked, beat-streamed context save/restore engine.
module e203_exu_regfile_ctx
    import e203_rfctx_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned NREGS     = 32,
    parameter int unsigned RFIDX_W   = $clog2(NREGS),
    parameter logic [31:0] SAVE_MASK = 32'hF003_FCE2,
    parameter int unsigned LANES     = 4,
    parameter int unsigned LOAD_RA   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [RFIDX_W-1:0]    rd1_idx,
    input  logic [RFIDX_W-1:0]    rd2_idx,
    output logic [XLEN-1:0]       rd1_dat,
    output logic [XLEN-1:0]       rd2_dat,
    input  logic                  wb_wen,
    input  logic [RFIDX_W-1:0]    wb_idx,
    input  logic [XLEN-1:0]       wb_dat,
    input  logic                  save_req,
    input  logic                  restore_req,
    input  logic [XLEN-1:0]       ra_dat,
    output logic                  busy,
    output logic                  done,
    output logic                  sv_valid,
    input  logic                  sv_ready,
    output logic [LANES*XLEN-1:0] sv_data,
    output logic                  sv_last,
    input  logic                  rs_valid,
    output logic                  rs_ready,
    input  logic [LANES*XLEN-1:0] rs_data,
    output logic [XLEN-1:0]       x1_r,
    output logic [XLEN-1:0]       x2_sp
);

    // Mask bits above the implemented register count are dropped.
    localparam logic [31:0] EFF_MASK = (NREGS >= 32) ? SAVE_MASK
                                     : (SAVE_MASK & 32'((64'd1 << NREGS) - 64'd1));
    localparam int unsigned NSLOT  = popcount(EFF_MASK);
    localparam int unsigned NBEAT  = nbeat(NSLOT, LANES);
    localparam int unsigned BCNT_W = (NBEAT > 1) ? $clog2(NBEAT) : 1;
    localparam int unsigned NPAD   = NBEAT * LANES;

    logic [XLEN-1:0]   regs     [NREGS];
    logic [XLEN-1:0]   regs_d   [NREGS];
    logic [XLEN-1:0]   slot_val [NPAD];
    logic [BCNT_W-1:0] bcnt;
    logic [XLEN-1:0]   ra_q;
    logic              save_fire;
    logic              restore_fire;
    logic              save_last;

    e203_rfctx_seq #(
        .XLEN   (XLEN),
        .NBEAT  (NBEAT),
        .BCNT_W (BCNT_W)
    ) u_seq (
        .clk          (clk),
        .rst          (rst),
        .save_req     (save_req),
        .restore_req  (restore_req),
        .ra_dat       (ra_dat),
        .sv_ready     (sv_ready),
        .rs_valid     (rs_valid),
        .busy         (busy),
        .done         (done),
        .sv_valid     (sv_valid),
        .sv_last      (sv_last),
        .rs_ready     (rs_ready),
        .bcnt         (bcnt),
        .ra_q         (ra_q),
        .save_fire    (save_fire),
        .restore_fire (restore_fire)
    );

    assign save_last = save_fire && sv_last;

    // Slot-ordered view of the saved registers, zero-padded to whole beats.
    always_comb begin
        for (int unsigned s = 0; s < NPAD; s++) begin
            slot_val[s] = '0;
            if (s < NSLOT) slot_val[s] = regs[slot_idx(EFF_MASK, s)];
        end
    end

    // Save payload for the current beat; lane 0 sits in the MSBs.
    always_comb begin
        int unsigned base;
        base    = 32'(bcnt) * LANES;
        sv_data = '0;
        for (int unsigned j = 0; j < LANES; j++) begin
            if (base + j < NSLOT) sv_data[(LANES-1-j)*XLEN +: XLEN] = slot_val[base + j];
        end
    end

    // Next register values: restore beat > x1 reload > write-back (IDLE only).
    // Each register's slot position is a constant, so the restore decode
    // collapses to a beat-counter compare per masked register.
    always_comb begin
        int unsigned s;
        s      = 0;
        regs_d = regs;
        for (int unsigned i = 1; i < NREGS; i++) begin
            s = popcount(EFF_MASK & ((32'd1 << i) - 32'd1));
            if (mask_has(EFF_MASK, i) && restore_fire && (32'(bcnt) == s / LANES)) begin
                regs_d[i] = rs_data[(LANES-1-(s % LANES))*XLEN +: XLEN];
            end else if (LOAD_RA != 0 && i == 1 && save_last) begin
                regs_d[i] = ra_q;
            end else if (wb_wen && !busy && 32'(wb_idx) == i) begin
                regs_d[i] = wb_dat;
            end
        end
        regs_d[0] = '0;
    end

    // Register array; reset clears everything and pre-empts any pending write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            regs <= regs_d;
        end
    end

    // Combinational read ports without write bypass; x0 reads zero.
    always_comb begin
        rd1_dat = '0;
        rd2_dat = '0;
        if (rd1_idx != '0 && 32'(rd1_idx) < NREGS) rd1_dat = regs[rd1_idx];
        if (rd2_idx != '0 && 32'(rd2_idx) < NREGS) rd2_dat = regs[rd2_idx];
    end

    assign x1_r  = regs[1];
    assign x2_sp = regs[2];

endmodule

// File: tb/tb_e203_exu_regfile_ctx.sv
// Self-checking bench for e203_exu_regfile_ctx (default config plus two LANES=3 masks).
module tb_e203_exu_regfile_ctx;

    localparam logic [31:0] MASK = 32'hF003_FCE2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [4:0]   rd1_idx, rd2_idx, wb_idx;
    logic [31:0]  rd1_dat, rd2_dat, wb_dat, ra_dat, x1_r, x2_sp;
    logic         wb_wen, save_req, restore_req, busy, done;
    logic         sv_valid, sv_ready, sv_last, rs_valid, rs_ready;
    logic [127:0] sv_data, rs_data;

    logic [4:0]   o_rd1_idx, o_rd2_idx, o_wb_idx;
    logic [31:0]  o_wb_dat, o_ra_dat;
    logic         o_wb_wen, o_save_req, o_restore_req, o_sv_ready, o_rs_valid;
    logic [95:0]  o_rs_data;
    logic [31:0]  p_rd1, p_rd2, p_x1, p_x2, q_rd1, q_rd2, q_x1, q_x2;
    logic         p_busy, p_done, p_svv, p_svl, p_rsr, q_busy, q_done, q_svv, q_svl, q_rsr;
    logic [95:0]  p_svd, q_svd;

    e203_exu_regfile_ctx dut (
        .clk(clk), .rst(rst), .rd1_idx(rd1_idx), .rd2_idx(rd2_idx),
        .rd1_dat(rd1_dat), .rd2_dat(rd2_dat), .wb_wen(wb_wen), .wb_idx(wb_idx),
        .wb_dat(wb_dat), .save_req(save_req), .restore_req(restore_req), .ra_dat(ra_dat),
        .busy(busy), .done(done), .sv_valid(sv_valid), .sv_ready(sv_ready),
        .sv_data(sv_data), .sv_last(sv_last), .rs_valid(rs_valid), .rs_ready(rs_ready),
        .rs_data(rs_data), .x1_r(x1_r), .x2_sp(x2_sp)
    );

    e203_exu_regfile_ctx #(.SAVE_MASK(32'h0000_0026), .LANES(3)) dut_p (
        .clk(clk), .rst(rst), .rd1_idx(o_rd1_idx), .rd2_idx(o_rd2_idx),
        .rd1_dat(p_rd1), .rd2_dat(p_rd2), .wb_wen(o_wb_wen), .wb_idx(o_wb_idx),
        .wb_dat(o_wb_dat), .save_req(o_save_req), .restore_req(o_restore_req), .ra_dat(o_ra_dat),
        .busy(p_busy), .done(p_done), .sv_valid(p_svv), .sv_ready(o_sv_ready),
        .sv_data(p_svd), .sv_last(p_svl), .rs_valid(o_rs_valid), .rs_ready(p_rsr),
        .rs_data(o_rs_data), .x1_r(p_x1), .x2_sp(p_x2)
    );

    e203_exu_regfile_ctx #(.SAVE_MASK(32'h0000_001E), .LANES(3)) dut_q (
        .clk(clk), .rst(rst), .rd1_idx(o_rd1_idx), .rd2_idx(o_rd2_idx),
        .rd1_dat(q_rd1), .rd2_dat(q_rd2), .wb_wen(o_wb_wen), .wb_idx(o_wb_idx),
        .wb_dat(o_wb_dat), .save_req(o_save_req), .restore_req(o_restore_req), .ra_dat(o_ra_dat),
        .busy(q_busy), .done(q_done), .sv_valid(q_svv), .sv_ready(o_sv_ready),
        .sv_data(q_svd), .sv_last(q_svl), .rs_valid(o_rs_valid), .rs_ready(q_rsr),
        .rs_data(o_rs_data), .x1_r(q_x1), .x2_sp(q_x2)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m [32];
    int          slots [$];
    logic [31:0] pay [$];
    int          nb;

    typedef struct {
        logic [4:0]  widx;
        logic [31:0] wdat;
        logic [4:0]  ridx;
        logic [31:0] exp;
    } vec_t;
    vec_t vt [6];

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference beat: slot list in ascending register order, lane 0 in the MSBs.
    function automatic logic [127:0] exp_beat(input int k);
        logic [127:0] r;
        r = '0;
        for (int j = 0; j < 4; j++) begin
            if (k * 4 + j < slots.size()) r[(3-j)*32 +: 32] = m[slots[k*4+j]];
        end
        return r;
    endfunction

    function automatic logic [127:0] pay_beat(input int k);
        logic [127:0] r;
        r = '0;
        for (int j = 0; j < 4; j++) begin
            if (k * 4 + j < pay.size()) r[(3-j)*32 +: 32] = pay[k*4+j];
            else                        r[(3-j)*32 +: 32] = $urandom;
        end
        return r;
    endfunction

    task automatic drive_pt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_write(input logic [4:0] idx, input logic [31:0] dat);
        wb_wen = 1'b1; wb_idx = idx; wb_dat = dat;
        drive_pt();
        wb_wen = 1'b0;
        if (idx != 0) m[idx] = dat;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0]  r;
        logic [127:0] prev_data;
        logic         prev_stall;
        int           got;
        int           b;

        rst = 1'b1;
        rd1_idx = '0; rd2_idx = '0; wb_idx = '0; wb_dat = '0; ra_dat = '0;
        wb_wen = 0; save_req = 0; restore_req = 0; sv_ready = 0; rs_valid = 0; rs_data = '0;
        o_rd1_idx = '0; o_rd2_idx = '0; o_wb_idx = '0; o_wb_dat = '0; o_ra_dat = '0;
        o_wb_wen = 0; o_save_req = 0; o_restore_req = 0; o_sv_ready = 0; o_rs_valid = 0;
        o_rs_data = '0;
        for (int i = 0; i < 32; i++) m[i] = '0;
        for (int i = 1; i < 32; i++) if (MASK[i]) slots.push_back(i);
        nb = (slots.size() + 3) / 4;

        vt[0] = '{5'd5,  32'hDEAD_BEEF, 5'd5,  32'hDEAD_BEEF};
        vt[1] = '{5'd0,  32'h0000_0001, 5'd0,  32'h0000_0000};
        vt[2] = '{5'd31, 32'h1234_5678, 5'd31, 32'h1234_5678};
        vt[3] = '{5'd1,  32'hA5A5_A5A5, 5'd1,  32'hA5A5_A5A5};
        vt[4] = '{5'd2,  32'h0BAD_F00D, 5'd2,  32'h0BAD_F00D};
        vt[5] = '{5'd7,  32'hCAFE_0007, 5'd5,  32'hDEAD_BEEF};

        // Reset state.
        drive_pt();
        drive_pt();
        rst = 1'b0;
        rd1_idx = 5'd1; rd2_idx = 5'd2;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sv_valid", sv_valid, 0);
        check("rst_sv_last", sv_last, 0);
        check("rst_rs_ready", rs_ready, 0);
        check("rst_x1", x1_r, 0);
        check("rst_rd2", rd2_dat, 0);
        drive_pt();

        // Table-driven write/read; the read in the write cycle must still show the old value.
        for (int v = 0; v < 6; v++) begin
            wb_wen = 1'b1; wb_idx = vt[v].widx; wb_dat = vt[v].wdat;
            rd1_idx = vt[v].ridx; rd2_idx = vt[v].ridx;
            @(negedge clk);
            check("vec_nobypass", rd1_dat, m[vt[v].ridx]);
            drive_pt();
            wb_wen = 1'b0;
            if (vt[v].widx != 0) m[vt[v].widx] = vt[v].wdat;
            @(negedge clk);
            check("vec_rd1", rd1_dat, vt[v].exp);
            check("vec_rd2", rd2_dat, vt[v].exp);
            drive_pt();
        end

        // Reset clears every register.
        rst = 1'b1;
        drive_pt();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) m[i] = '0;
        for (int i = 0; i < 32; i++) begin
            rd1_idx = 5'(i); rd2_idx = 5'(31 - i);
            @(negedge clk);
            check("clr_rd1", rd1_dat, 0);
            check("clr_rd2", rd2_dat, 0);
            drive_pt();
        end

        // Random IDLE write-back / read traffic against the array model.
        for (int c = 0; c < 300; c++) begin
            wb_wen = 1'($urandom_range(0, 1)); wb_idx = 5'($urandom); wb_dat = $urandom;
            rd1_idx = 5'($urandom); rd2_idx = 5'($urandom);
            @(negedge clk);
            check("rnd_rd1", rd1_dat, m[rd1_idx]);
            check("rnd_rd2", rd2_dat, m[rd2_idx]);
            check("rnd_x2", x2_sp, m[2]);
            drive_pt();
            if (wb_wen && wb_idx != 0) m[wb_idx] = wb_dat;
        end
        wb_wen = 1'b0;

        // Default save of xi = 0x100+i with sv_ready held high.
        for (int i = 1; i < 32; i++) idle_write(5'(i), 32'h100 + 32'(i));
        save_req = 1'b1; ra_dat = 32'h8000_0040; sv_ready = 1'b1;
        drive_pt();
        save_req = 1'b0; ra_dat = '0;
        for (int k = 0; k < 4; k++) begin
            wb_wen = 1'b1; wb_idx = 5'd3; wb_dat = 32'hFFFF_FFFF;
            @(negedge clk);
            check("sv_busy", busy, 1);
            check("sv_valid", sv_valid, 1);
            check("sv_done_low", done, 0);
            check("sv_beat_model", sv_data, exp_beat(k));
            check("sv_last", sv_last, (k == 3));
            if (k == 0) check("sv_beat0", sv_data, 128'h00000101_00000105_00000106_00000107);
            if (k == 3) check("sv_beat3", sv_data, 128'h0000011C_0000011D_0000011E_0000011F);
            drive_pt();
        end
        wb_wen = 1'b0; sv_ready = 1'b0;
        m[1] = 32'h8000_0040;
        rd1_idx = 5'd3;
        @(negedge clk);
        check("sv_done", done, 1);
        check("sv_idle", busy, 0);
        check("sv_valid_off", sv_valid, 0);
        check("sv_x1_ra", x1_r, 32'h8000_0040);
        check("sv_wb_ignored", rd1_dat, 32'h103);
        drive_pt();
        @(negedge clk);
        check("sv_done_pulse", done, 0);
        drive_pt();

        // Race (save wins) followed by a save under toggling backpressure.
        for (int i = 1; i < 32; i++) idle_write(5'(i), $urandom);
        r = $urandom;
        save_req = 1'b1; restore_req = 1'b1; ra_dat = r; sv_ready = 1'b0;
        drive_pt();
        save_req = 1'b0; restore_req = 1'b0; ra_dat = '0;
        got = 0; prev_stall = 1'b0; prev_data = '0;
        for (int c = 0; c < 200 && got < nb; c++) begin
            sv_ready = ((c % 2) == 1) || ($urandom_range(0, 3) == 0);
            @(negedge clk);
            check("bp_valid", sv_valid, 1);
            check("race_no_restore", rs_ready, 0);
            if (prev_stall) check("bp_stable", sv_data, prev_data);
            if (sv_ready) begin
                check("bp_beat", sv_data, exp_beat(got));
                check("bp_last", sv_last, (got == nb - 1));
                got++;
            end
            prev_stall = !sv_ready;
            prev_data  = sv_data;
            drive_pt();
        end
        sv_ready = 1'b0;
        if (got != nb) check("bp_timeout", got, nb);
        m[1] = r;
        @(negedge clk);
        check("bp_done", done, 1);
        check("bp_x1", x1_r, r);
        drive_pt();
        @(negedge clk);
        check("race_dropped_busy", busy, 0);
        check("race_dropped_rs", rs_ready, 0);
        drive_pt();

        // Restore with rs_valid gaps; write-back attempts during RESTORE are ignored.
        pay.delete();
        for (int s = 0; s < slots.size(); s++) pay.push_back($urandom);
        restore_req = 1'b1;
        drive_pt();
        restore_req = 1'b0;
        b = 0;
        for (int c = 0; c < 200 && b < nb; c++) begin
            rs_valid = ($urandom_range(0, 2) != 0);
            rs_data  = pay_beat(b);
            wb_wen = 1'b1; wb_idx = ((c % 2) == 1) ? 5'd2 : 5'd5; wb_dat = $urandom;
            @(negedge clk);
            check("rs_ready", rs_ready, 1);
            check("rs_busy", busy, 1);
            check("rs_no_sv", sv_valid, 0);
            if (rs_valid) b++;
            drive_pt();
        end
        rs_valid = 1'b0; wb_wen = 1'b0;
        if (b != nb) check("rs_timeout", b, nb);
        for (int s = 0; s < slots.size(); s++) m[slots[s]] = pay[s];
        @(negedge clk);
        check("rs_done", done, 1);
        check("rs_idle", busy, 0);
        check("rs_x2_kept", x2_sp, m[2]);
        drive_pt();
        for (int i = 0; i < 32; i++) begin
            rd1_idx = 5'(i); rd2_idx = 5'((i + 7) % 32);
            @(negedge clk);
            check("rs_rd1", rd1_dat, m[i]);
            check("rs_rd2", rd2_dat, m[(i + 7) % 32]);
            drive_pt();
        end

        // Reset asserted while beat 2 is on the bus.
        save_req = 1'b1; ra_dat = 32'h5555_AAAA; sv_ready = 1'b1;
        drive_pt();
        save_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("mid_beat", sv_data, exp_beat(k));
            if (k < 2) drive_pt();
        end
        #2 rst = 1'b1;
        drive_pt();
        rst = 1'b0; sv_ready = 1'b0;
        for (int i = 0; i < 32; i++) m[i] = '0;
        @(negedge clk);
        check("mid_busy", busy, 0);
        check("mid_sv_valid", sv_valid, 0);
        check("mid_sv_last", sv_last, 0);
        check("mid_done", done, 0);
        check("mid_x1", x1_r, 0);
        drive_pt();
        @(negedge clk);
        check("mid_stays_idle", busy, 0);
        drive_pt();

        // LANES=3 configurations: mask 0x26 (one beat) and 0x1E (partial second beat).
        for (int i = 1; i <= 5; i++) begin
            o_wb_wen = 1'b1; o_wb_idx = 5'(i); o_wb_dat = 32'h200 + 32'(i);
            drive_pt();
        end
        o_wb_wen = 1'b0;
        o_save_req = 1'b1; o_ra_dat = 32'h1111_2222; o_sv_ready = 1'b1;
        drive_pt();
        o_save_req = 1'b0;
        @(negedge clk);
        check("odd_p_valid", p_svv, 1);
        check("odd_p_beat0", p_svd, 96'h00000201_00000202_00000205);
        check("odd_p_last", p_svl, 1);
        check("odd_q_beat0", q_svd, 96'h00000201_00000202_00000203);
        check("odd_q_last0", q_svl, 0);
        drive_pt();
        @(negedge clk);
        check("odd_p_done", p_done, 1);
        check("odd_p_idle", p_busy, 0);
        check("odd_q_beat1", q_svd, 96'h00000204_00000000_00000000);
        check("odd_q_last1", q_svl, 1);
        drive_pt();
        o_sv_ready = 1'b0;
        @(negedge clk);
        check("odd_q_done", q_done, 1);
        check("odd_p_x1", p_x1, 32'h1111_2222);
        check("odd_q_x1", q_x1, 32'h1111_2222);
        check("odd_q_x2", q_x2, 32'h202);
        drive_pt();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
